noc_echo_responder: RTL and testbench

- Single-channel NoC endpoint for the far side of a compute tile's NoC link: consumes packets the tile emits on noc_out_* and returns each one on the tile's noc_in_*.
- Each packet is buffered whole, then echoed with its header rewritten so it routes back to the sender.
- Used as a drop-in responder in single-tile benches and as a link-level self-test block in small systems.

---
 rtl/noc_echo_pkg.sv | 22 ++
 rtl/noc_echo_pktbuf.sv | 38 +++
 rtl/noc_echo_responder.sv | 104 ++++++++++
 tb/tb_noc_echo_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_echo_pkg.sv
// noc_echo_pkg: shared state encoding and header field positions for the echo responder.
package noc_echo_pkg;
  typedef enum logic [1:0] {RX, TX, DROP} state_t;
  function automatic int dest_msb(input int fw);
    return fw - 1;
  endfunction
  function automatic int dest_lsb(input int fw, input int dw);
    return fw - dw;
  endfunction
  function automatic int class_msb(input int fw, input int dw);
    return fw - dw - 1;
  endfunction
  function automatic int class_lsb(input int fw, input int dw, input int cw);
    return fw - dw - cw;
  endfunction
  function automatic int src_msb(input int fw, input int dw, input int cw);
    return fw - dw - cw - 1;
  endfunction
  function automatic int src_lsb(input int fw, input int dw, input int cw);
    return fw - 2 * dw - cw;
  endfunction
endpackage

// File: rtl/noc_echo_pktbuf.sv
// noc_echo_pktbuf: whole-packet flit store with write/read pointers and stored last index.
module noc_echo_pktbuf #(
  parameter int FLIT_WIDTH  = 32,
  parameter int MAX_PKT_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [FLIT_WIDTH-1:0] i_wr_data,
  input  logic                  i_len_set,
  input  logic                  i_rd_inc,
  input  logic                  i_clr,
  output logic [FLIT_WIDTH-1:0] o_rd_data,
  output logic                  o_full,
  output logic                  o_rd_first,
  output logic                  o_rd_last
);
  localparam int PW = MAX_PKT_LEN > 1 ? $clog2(MAX_PKT_LEN) : 1;
  logic [FLIT_WIDTH-1:0] r_buf [MAX_PKT_LEN];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_last_idx;
  always_ff @(posedge clk)
    if (i_wr_en) r_buf[r_wr_ptr] <= i_wr_data;
  // len is kept as the index of the last flit so MAX_PKT_LEN fits in PW bits
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_last_idx <= '0;
    end else begin
      r_wr_ptr <= i_clr ? '0 : i_wr_en ? r_wr_ptr + PW'(1) : r_wr_ptr;
      r_rd_ptr <= i_clr ? '0 : i_rd_inc ? r_rd_ptr + PW'(1) : r_rd_ptr;
      if (i_len_set) r_last_idx <= r_wr_ptr;
    end
  assign o_rd_data  = r_buf[r_rd_ptr];
  assign o_full     = r_wr_ptr == PW'(MAX_PKT_LEN - 1);
  assign o_rd_first = r_rd_ptr == '0;
  assign o_rd_last  = r_rd_ptr == r_last_idx;
endmodule

// File: rtl/noc_echo_responder.sv
// noc_echo_responder: buffers each packet whole and echoes it back with dest/src swapped to TILE_ID.
module noc_echo_responder
  import noc_echo_pkg::*;
#(
  parameter int FLIT_WIDTH  = 32,
  parameter int MAX_PKT_LEN = 8,
  parameter int TILE_ID     = 1,
  parameter int DEST_WIDTH  = 5,
  parameter int CLASS_WIDTH = 3,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  echo_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic                  busy
);
  localparam int DMSB = dest_msb(FLIT_WIDTH);
  localparam int DLSB = dest_lsb(FLIT_WIDTH, DEST_WIDTH);
  localparam int SMSB = src_msb(FLIT_WIDTH, DEST_WIDTH, CLASS_WIDTH);
  localparam int SLSB = src_lsb(FLIT_WIDTH, DEST_WIDTH, CLASS_WIDTH);
  state_t r_state, w_next;
  logic w_wr, w_len_set, w_rd, w_clr, w_echo_inc, w_drop_inc;
  logic w_full, w_rd_first, w_rd_last;
  logic [FLIT_WIDTH-1:0] w_rd_data, w_hdr;
  logic [CNT_WIDTH-1:0] r_echo_cnt, r_drop_cnt, w_echo_nxt, w_drop_nxt;
  noc_echo_pktbuf #(.FLIT_WIDTH(FLIT_WIDTH), .MAX_PKT_LEN(MAX_PKT_LEN)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr),
    .i_wr_data (in_flit),
    .i_len_set (w_len_set),
    .i_rd_inc  (w_rd),
    .i_clr     (w_clr),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_rd_first(w_rd_first),
    .o_rd_last (w_rd_last)
  );
  always_comb begin
    w_next     = r_state;
    w_wr       = 1'b0;
    w_len_set  = 1'b0;
    w_rd       = 1'b0;
    w_clr      = 1'b0;
    w_echo_inc = 1'b0;
    w_drop_inc = 1'b0;
    case (r_state)
      RX: if (in_valid) begin
        w_wr = 1'b1;
        if (in_last) begin
          w_len_set = 1'b1;
          w_next    = TX;
        end else if (w_full) w_next = DROP;
      end
      TX: if (out_ready) begin
        w_rd = 1'b1;
        if (w_rd_last) begin
          w_clr      = 1'b1;
          w_echo_inc = 1'b1;
          w_next     = RX;
        end
      end
      DROP: if (in_valid && in_last) begin
        w_clr      = 1'b1;
        w_drop_inc = 1'b1;
        w_next     = RX;
      end
      default: w_next = RX;
    endcase
  end
  always_comb begin
    w_hdr            = w_rd_data;
    w_hdr[DMSB:DLSB] = w_rd_data[SMSB:SLSB];
    w_hdr[SMSB:SLSB] = DEST_WIDTH'(TILE_ID);
  end
  assign w_echo_nxt = (w_echo_inc && ~&r_echo_cnt) ? r_echo_cnt + CNT_WIDTH'(1) : r_echo_cnt;
  assign w_drop_nxt = (w_drop_inc && ~&r_drop_cnt) ? r_drop_cnt + CNT_WIDTH'(1) : r_drop_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= RX;
      r_echo_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_echo_cnt <= w_echo_nxt;
      r_drop_cnt <= w_drop_nxt;
    end
  assign in_ready  = r_state != TX;
  assign out_valid = r_state == TX;
  assign busy      = r_state != RX;
  assign out_last  = out_valid && w_rd_last;
  assign out_flit  = out_valid ? (w_rd_first ? w_hdr : w_rd_data) : '0;
  assign echo_cnt  = r_echo_cnt;
  assign drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_noc_echo_responder.sv
// tb_noc_echo_responder: scoreboard bench for the echo responder (single, multi, full, drop, reset, saturation).
module tb_noc_echo_responder;
  logic        clk = 0, rst_n = 0;
  logic [31:0] in_flit = '0, out_flit;
  logic        in_last = 0, in_valid = 0, in_ready;
  logic        out_last, out_valid, out_ready = 0, busy;
  logic [15:0] echo_cnt, drop_cnt;
  int errors = 0, checks = 0;
  logic [32:0] sb[$];
  logic [31:0] pkt[$];

  noc_echo_responder dut (
    .clk(clk), .rst_n(rst_n), .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .echo_cnt(echo_cnt), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] echo_hdr(input logic [31:0] f);
    return {f[23:19], f[26:24], 5'd1, f[18:0]};
  endfunction

  task automatic send(input bit echo, output bit saw_valid);
    bit acc;
    saw_valid = 0;
    for (int i = 0; i < pkt.size(); i++) begin
      acc = 0;
      in_flit = pkt[i];
      in_last = (i == pkt.size() - 1);
      in_valid = 1;
      if (echo) sb.push_back({in_last, i == 0 ? echo_hdr(pkt[i]) : pkt[i]});
      for (int n = 0; n < 40 && !acc; n++) begin
        @(negedge clk);
        acc = in_ready;
        saw_valid |= out_valid;
        @(posedge clk); #1;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL send_timeout flit %0d: in_ready stayed 0", i);
      end
    end
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic drain(input bit toggle, output int stall_cycles);
    logic [31:0] held;
    logic [32:0] exp;
    bit hold;
    hold = 0;
    held = '0;
    stall_cycles = 0;
    for (int n = 0; n < 100 && sb.size() > 0; n++) begin
      out_ready = toggle ? (n % 2 == 0) : 1'b1;
      @(negedge clk);
      if (!in_ready) stall_cycles++;
      if (hold && out_valid) begin
        checks++;
        if (out_flit !== held) begin
          errors++;
          $display("FAIL stable: out_flit=%h held=%h", out_flit, held);
        end
      end
      hold = out_valid && !out_ready;
      held = out_flit;
      if (out_valid && out_ready) begin
        exp = sb.pop_front();
        checks++;
        if ({out_last, out_flit} !== exp) begin
          errors++;
          $display("FAIL echo_flit: got last=%b flit=%h want last=%b flit=%h",
                   out_last, out_flit, exp[32], exp[31:0]);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d flits never echoed", sb.size());
      sb.delete();
    end
    out_ready = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_last, out_flit, echo_cnt, drop_cnt, busy} !== {3'b100, 32'h0, 16'h0, 16'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_vals: rdy=%b vld=%b last=%b flit=%h echo=%0d drop=%0d busy=%b",
               in_ready, out_valid, out_last, out_flit, echo_cnt, drop_cnt, busy);
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    bit sv;
    int st;
    pkt = '{32'h2000_0000};
    send(1, sv);
    checks++;
    if (out_valid !== 1 || out_last !== 1 || out_flit !== 32'h0008_0000) begin
      errors++;
      $display("FAIL single_latency: vld=%b last=%b flit=%h want 1 1 00080000", out_valid, out_last, out_flit);
    end
    drain(0, st);
    checks++;
    if (echo_cnt !== 16'd1) begin
      errors++;
      $display("FAIL single_echo_cnt: got %0d want 1", echo_cnt);
    end
  endtask

  task automatic test_three;
    bit sv;
    int st;
    pkt = '{32'h0800_0000, 32'hDEAD_BEEF, 32'h1234_5678};
    send(1, sv);
    drain(0, st);
    checks++;
    if (st != 3 || in_ready !== 1) begin
      errors++;
      $display("FAIL three_stall: in_ready low %0d cycles want 3, now in_ready=%b", st, in_ready);
    end
  endtask

  task automatic test_full_toggle;
    bit sv;
    int st;
    pkt.delete();
    for (int i = 0; i < 8; i++) pkt.push_back(32'h5A00_0000 + 32'(i * 32'h0101_0101));
    send(1, sv);
    drain(1, st);
    checks++;
    if (echo_cnt !== 16'd3 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL full_counts: echo=%0d drop=%0d want 3 0", echo_cnt, drop_cnt);
    end
  endtask

  task automatic test_drop;
    bit sv;
    int st;
    pkt.delete();
    for (int i = 0; i < 10; i++) pkt.push_back(32'hC000_0000 | 32'(i));
    send(0, sv);
    checks++;
    if (sv || drop_cnt !== 16'd1 || echo_cnt !== 16'd3 || busy !== 0) begin
      errors++;
      $display("FAIL drop: saw_valid=%b drop=%0d echo=%0d busy=%b want 0 1 3 0", sv, drop_cnt, echo_cnt, busy);
    end
    pkt = '{32'h4871_2345};
    send(1, sv);
    drain(0, st);
    checks++;
    if (echo_cnt !== 16'd4) begin
      errors++;
      $display("FAIL after_drop_echo_cnt: got %0d want 4", echo_cnt);
    end
  endtask

  task automatic test_mid_reset;
    bit sv;
    int st;
    logic [32:0] exp;
    pkt = '{32'h1890_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    send(1, sv);
    out_ready = 1;
    @(negedge clk);
    exp = sb.pop_front();
    checks++;
    if ({out_last, out_flit} !== exp) begin
      errors++;
      $display("FAIL midrst_hdr: got %b %h want %b %h", out_last, out_flit, exp[32], exp[31:0]);
    end
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 0 || in_ready !== 1 || echo_cnt !== 0 || drop_cnt !== 0) begin
      errors++;
      $display("FAIL midrst_async: vld=%b rdy=%b echo=%0d drop=%0d want 0 1 0 0", out_valid, in_ready, echo_cnt, drop_cnt);
    end
    sb.delete();
    out_ready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    pkt = '{32'hF8F8_0F0F};
    send(1, sv);
    drain(0, st);
    checks++;
    if (echo_cnt !== 16'd1) begin
      errors++;
      $display("FAIL midrst_after: echo=%0d want 1", echo_cnt);
    end
  endtask

  task automatic test_saturate;
    bit sv;
    int st;
    force dut.r_echo_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.r_echo_cnt;
    @(negedge clk);
    checks++;
    if (echo_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_preload: got %h want ffff", echo_cnt);
    end
    @(posedge clk); #1;
    pkt = '{32'h0000_00AA, 32'h0000_00BB};
    send(1, sv);
    drain(0, st);
    checks++;
    if (echo_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: got %h want ffff", echo_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_full_toggle();
    test_drop();
    test_mid_reset();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
